// File: rtl/cr_rbus_ring_master_pkg.sv
// Shared types for the rbus ring master: FSM states, completion status codes
// and the ring payload structure.
package cr_rbus_ring_master_pkg;

  localparam int unsigned N_RBUS_ADDR_BITS    = 16;
  localparam int unsigned N_RBUS_DATA_BITS    = 32;
  localparam int unsigned TIMEOUT_CYCLES_DFLT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rbus_mstr_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rbus_rsp_status_e;

  // One ring hop: command fields travel forward, ack/err_ack/rd_data come back.
  typedef struct packed {
    logic [N_RBUS_ADDR_BITS-1:0] addr;
    logic [N_RBUS_DATA_BITS-1:0] wr_data;
    logic [N_RBUS_DATA_BITS-1:0] rd_data;
    logic                        wr_strb;
    logic                        rd_strb;
    logic                        ack;
    logic                        err_ack;
  } rbus_ring_t;

endpackage : cr_rbus_ring_master_pkg

// File: rtl/cr_rbus_mstr_timeout.sv
// Clear/enable cycle counter with a registered terminal-count flag that is high
// while the count sits at TIMEOUT_CYCLES-1; the count holds there instead of wrapping.
module cr_rbus_mstr_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tc_d = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule : cr_rbus_mstr_timeout

// File: rtl/cr_rbus_ring_master.sv
// Head-of-ring initiator: issues one register command onto the rbus ring, terminates
// the returning ack/err_ack/rd_data and hands back a completion with status.
module cr_rbus_ring_master
  import cr_rbus_ring_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
  parameter int unsigned STRAY_CNT_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
  input  logic [N_RBUS_DATA_BITS-1:0] req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [1:0]                  rsp_status,
  output logic [N_RBUS_DATA_BITS-1:0] rsp_rdata,
  output rbus_ring_t                  rbus_ring_o,
  input  rbus_ring_t                  rbus_ring_i,
  output logic                        busy,
  output logic [STRAY_CNT_BITS-1:0]   stray_ack_cnt
);

  rbus_mstr_state_e            state_q, state_d;
  rbus_rsp_status_e            status_q, status_d;
  logic                        wr_q, wr_d;
  logic [N_RBUS_DATA_BITS-1:0] rdata_q, rdata_d;
  rbus_ring_t                  ring_q, ring_d;
  logic [STRAY_CNT_BITS-1:0]   stray_q, stray_d;
  logic                        tmr_tc;
  logic                        ring_i_unused;

  // Forward-travelling fields on the return path are not used by the head.
  assign ring_i_unused = ^{rbus_ring_i.addr, rbus_ring_i.wr_data,
                           rbus_ring_i.wr_strb, rbus_ring_i.rd_strb};

  cr_rbus_mstr_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ISSUE),
    .en_i  (state_q == WAIT),
    .tc_o  (tmr_tc)
  );

  // Next-state logic; ring_o is loaded on transitions so it is valid in the target state.
  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    wr_d           = wr_q;
    rdata_d        = rdata_q;
    ring_d         = ring_q;
    ring_d.wr_strb = 1'b0;
    ring_d.rd_strb = 1'b0;
    ring_d.rd_data = '0;
    ring_d.ack     = 1'b0;
    ring_d.err_ack = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d           = req_wr;
          ring_d.addr    = req_addr;
          ring_d.wr_data = req_wr ? req_wdata : '0;
          ring_d.wr_strb = req_wr;
          ring_d.rd_strb = !req_wr;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // err_ack beats ack, and any ack beats the timeout in the same cycle.
        if (rbus_ring_i.err_ack) begin
          status_d = RSP_ERR;
          rdata_d  = '0;
          state_d  = RESP;
        end else if (rbus_ring_i.ack) begin
          status_d = RSP_OK;
          rdata_d  = wr_q ? '0 : rbus_ring_i.rd_data;
          state_d  = RESP;
        end else if (tmr_tc) begin
          status_d = RSP_TIMEOUT;
          rdata_d  = '0;
          state_d  = RESP;
        end
        if (state_d == RESP) begin
          ring_d.addr    = '0;
          ring_d.wr_data = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    stray_d = stray_q;
    if ((rbus_ring_i.ack || rbus_ring_i.err_ack) && (state_q != WAIT) && (stray_q != '1)) begin
      stray_d = stray_q + STRAY_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= RSP_OK;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      ring_q   <= '0;
      stray_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      ring_q   <= ring_d;
      stray_q  <= stray_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_status    = 2'(status_q);
  assign rsp_rdata     = rdata_q;
  assign rbus_ring_o   = ring_q;
  assign stray_ack_cnt = stray_q;

endmodule : cr_rbus_ring_master
